ps2_mouse_stream_ctrl: RTL and testbench

//  Next-generation PS/2 mouse stream-mode controller between the PS/2 rx/tx byte engines and user logic.

---
 rtl/ps2_mouse_stream_ctrl_pkg.sv | 40 ++++
 rtl/ps2_mouse_stream_ctrl_if.sv | 26 ++
 rtl/ps2_mouse_stream_ctrl_sat_accum.sv | 40 ++++
 rtl/ps2_mouse_stream_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_ps2_mouse_stream_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_mouse_stream_ctrl_pkg.sv
// Shared constants, state encoding and packet fields for the PS/2 mouse stream-mode controller.
package ps2_mouse_stream_ctrl_pkg;

   localparam logic [7:0] CMD_STREAM_ON  = 8'hF4;
   localparam logic [7:0] CMD_STREAM_OFF = 8'hF5;
   localparam logic [7:0] RSP_ACK        = 8'hFA;
   localparam logic [7:0] RSP_RESEND     = 8'hFE;

   localparam int unsigned TO_CYCLES_DEFAULT = 2_000_000;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_TX,
      ST_WAIT_ACK,
      ST_PK1,
      ST_PK2,
      ST_PK3,
      ST_PK4,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic [2:0] btn;
      logic       xs;
      logic       ys;
      logic       xo;
      logic       yo;
      logic [7:0] xb;
      logic [7:0] yb;
      logic [3:0] zb;
   } pkt_t;

   // An overflowed axis contributes the largest delta of its sign instead of the raw byte.
   function automatic logic [8:0] eff_delta(input logic sgn, input logic [7:0] mag, input logic ovf);
      if (ovf) return sgn ? 9'h100 : 9'h0FF;
      return {sgn, mag};
   endfunction

endpackage

// File: rtl/ps2_mouse_stream_ctrl_if.sv
// Byte-engine side of the controller: command transmit strobe/data and receive/transmit-done strobes.
interface ps2_mouse_stream_ctrl_if;

   logic       wr_ps2;
   logic [7:0] tx_data;
   logic [7:0] rx_data;
   logic       rx_done_tick;
   logic       tx_done_tick;

   modport master (
      output wr_ps2,
      output tx_data,
      input  rx_data,
      input  rx_done_tick,
      input  tx_done_tick
   );

   modport slave (
      input  wr_ps2,
      input  tx_data,
      output rx_data,
      output rx_done_tick,
      output tx_done_tick
   );

endinterface

// File: rtl/ps2_mouse_stream_ctrl_sat_accum.sv
// Signed position accumulator: adds a 9-bit signed delta and saturates at the POS_W range limits.
module sat_accum #(
   parameter int unsigned POS_W = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr_i,
   input  logic                    en_i,
   input  logic signed [8:0]       delta_i,
   output logic signed [POS_W-1:0] pos_o
);

   // Sum is one bit wider than the wider operand so it can never wrap before the clamp.
   localparam int unsigned SW = ((POS_W > 9) ? POS_W : 9) + 1;
   localparam logic signed [SW-1:0] PMAX = {{(SW-POS_W+1){1'b0}}, {(POS_W-1){1'b1}}};
   localparam logic signed [SW-1:0] PMIN = {{(SW-POS_W+1){1'b1}}, {(POS_W-1){1'b0}}};

   logic signed [POS_W-1:0] pos_q, pos_d;
   logic signed [SW-1:0]    sum;

   always_comb begin
      sum   = {{(SW-POS_W){pos_q[POS_W-1]}}, pos_q} + {{(SW-9){delta_i[8]}}, delta_i};
      pos_d = pos_q;
      if (clr_i) begin
         pos_d = '0;
      end else if (en_i) begin
         if (sum > PMAX)      pos_d = PMAX[POS_W-1:0];
         else if (sum < PMIN) pos_d = PMIN[POS_W-1:0];
         else                 pos_d = sum[POS_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pos_q <= '0;
      else     pos_q <= pos_d;
   end

   assign pos_o = pos_q;

endmodule

// File: rtl/ps2_mouse_stream_ctrl.sv
// PS/2 mouse stream-mode controller: F4/F5 command handshake with retry, packet decode,
// resynchronisation and saturating X/Y position integration.
module ps2_mouse_stream_ctrl
   import ps2_mouse_stream_ctrl_pkg::*;
#(
   parameter int unsigned PKT_BYTES = 3,
   parameter int unsigned POS_W     = 12,
   parameter int unsigned TO_CYCLES = TO_CYCLES_DEFAULT,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    stream_enable,
   input  logic                    stream_disable,
   input  logic                    pos_clr,
   ps2_mouse_stream_ctrl_if.master ps2,
   output logic [8:0]              x_delta,
   output logic [8:0]              y_delta,
   output logic [3:0]              z_delta,
   output logic [2:0]              btn,
   output logic                    x_ovf,
   output logic                    y_ovf,
   output logic signed [POS_W-1:0] x_pos,
   output logic signed [POS_W-1:0] y_pos,
   output logic                    streaming,
   output logic                    package_done_tick,
   output logic                    disable_done_tick,
   output logic                    err_tick
);

   localparam int unsigned TW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);

   state_e        state_q, state_d;
   logic [7:0]    cmd_q, cmd_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          pend_q, pend_d;
   logic          streaming_q, streaming_d;
   pkt_t          pkt_q, pkt_d;
   pkt_t          out_q, out_d;
   logic          pkg_tick_q, pkg_tick_d;
   logic          dis_tick_q, dis_tick_d;
   logic          err_tick_q, err_tick_d;

   logic          timeout, retry_req, start_off, acc_en;
   logic [8:0]    x_eff, y_eff;

   assign timeout = (timer_q == TO_LAST);

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      retry_d     = retry_q;
      timer_d     = timer_q;
      pend_d      = pend_q;
      streaming_d = streaming_q;
      pkt_d       = pkt_q;
      out_d       = out_q;
      pkg_tick_d  = 1'b0;
      dis_tick_d  = 1'b0;
      err_tick_d  = 1'b0;
      acc_en      = 1'b0;
      retry_req   = 1'b0;
      start_off   = 1'b0;
      ps2.wr_ps2  = 1'b0;
      ps2.tx_data = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (stream_enable) begin
               state_d = ST_SEND;
               cmd_d   = CMD_STREAM_ON;
               retry_d = '0;
            end else if (stream_disable) begin
               start_off = 1'b1;
            end
         end
         ST_SEND: begin
            ps2.wr_ps2  = 1'b1;
            ps2.tx_data = cmd_q;
            state_d     = ST_WAIT_TX;
            timer_d     = '0;
         end
         ST_WAIT_TX: begin
            if (ps2.tx_done_tick) begin
               state_d = ST_WAIT_ACK;
               timer_d = '0;
            end else if (timeout) begin
               retry_req = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_WAIT_ACK: begin
            // While disabling, leftover packet bytes are expected and must not restart the timer.
            if (ps2.rx_done_tick && ps2.rx_data == RSP_ACK) begin
               if (cmd_q == CMD_STREAM_ON) begin
                  streaming_d = 1'b1;
                  state_d     = ST_PK1;
                  timer_d     = '0;
               end else begin
                  dis_tick_d = 1'b1;
                  state_d    = ST_IDLE;
               end
            end else if (ps2.rx_done_tick &&
                         (ps2.rx_data == RSP_RESEND || cmd_q == CMD_STREAM_ON)) begin
               retry_req = 1'b1;
            end else if (timeout) begin
               retry_req = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_PK1: begin
            if (stream_disable) begin
               start_off = 1'b1;
            end else if (ps2.rx_done_tick && ps2.rx_data[3]) begin
               pkt_d.btn = ps2.rx_data[2:0];
               pkt_d.xs  = ps2.rx_data[4];
               pkt_d.ys  = ps2.rx_data[5];
               pkt_d.xo  = ps2.rx_data[6];
               pkt_d.yo  = ps2.rx_data[7];
               state_d   = ST_PK2;
               timer_d   = '0;
            end
         end
         ST_PK2, ST_PK3, ST_PK4: begin
            if (stream_disable) pend_d = 1'b1;
            if (ps2.rx_done_tick) begin
               timer_d = '0;
               if (state_q == ST_PK2) begin
                  pkt_d.xb = ps2.rx_data;
                  state_d  = ST_PK3;
               end else if (state_q == ST_PK3) begin
                  pkt_d.yb = ps2.rx_data;
                  state_d  = (PKT_BYTES == 4) ? ST_PK4 : ST_DONE;
               end else begin
                  pkt_d.zb = ps2.rx_data[3:0];
                  state_d  = ST_DONE;
               end
            end else if (timeout) begin
               if (pend_d) start_off = 1'b1;
               else        state_d   = ST_PK1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_DONE: begin
            out_d      = pkt_q;
            pkg_tick_d = 1'b1;
            acc_en     = 1'b1;
            if (pend_q || stream_disable) start_off = 1'b1;
            else                          state_d   = ST_PK1;
         end
         default: state_d = ST_IDLE;
      endcase

      if (retry_req) begin
         if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_SEND;
         end else begin
            err_tick_d  = 1'b1;
            streaming_d = 1'b0;
            state_d     = ST_IDLE;
         end
      end

      // Every fresh F5 request starts with a full retry budget.
      if (start_off) begin
         state_d     = ST_SEND;
         cmd_d       = CMD_STREAM_OFF;
         retry_d     = '0;
         streaming_d = 1'b0;
         pend_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cmd_q       <= '0;
         retry_q     <= '0;
         timer_q     <= '0;
         pend_q      <= 1'b0;
         streaming_q <= 1'b0;
         pkt_q       <= '0;
         out_q       <= '0;
         pkg_tick_q  <= 1'b0;
         dis_tick_q  <= 1'b0;
         err_tick_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         retry_q     <= retry_d;
         timer_q     <= timer_d;
         pend_q      <= pend_d;
         streaming_q <= streaming_d;
         pkt_q       <= pkt_d;
         out_q       <= out_d;
         pkg_tick_q  <= pkg_tick_d;
         dis_tick_q  <= dis_tick_d;
         err_tick_q  <= err_tick_d;
      end
   end

   assign x_eff = eff_delta(pkt_q.xs, pkt_q.xb, pkt_q.xo);
   assign y_eff = eff_delta(pkt_q.ys, pkt_q.yb, pkt_q.yo);

   sat_accum #(.POS_W(POS_W)) u_x_accum (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (pos_clr),
      .en_i    (acc_en),
      .delta_i (x_eff),
      .pos_o   (x_pos)
   );

   sat_accum #(.POS_W(POS_W)) u_y_accum (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (pos_clr),
      .en_i    (acc_en),
      .delta_i (y_eff),
      .pos_o   (y_pos)
   );

   assign x_delta           = {out_q.xs, out_q.xb};
   assign y_delta           = {out_q.ys, out_q.yb};
   assign z_delta           = (PKT_BYTES == 4) ? out_q.zb : '0;
   assign btn               = out_q.btn;
   assign x_ovf             = out_q.xo;
   assign y_ovf             = out_q.yo;
   assign streaming         = streaming_q;
   assign package_done_tick = pkg_tick_q;
   assign disable_done_tick = dis_tick_q;
   assign err_tick          = err_tick_q;

endmodule

// File: tb/tb_ps2_mouse_stream_ctrl.sv
// Directed bench: a 3-byte/12-bit instance and a 4-byte/8-bit instance driven by one linear sequence.
module tb_ps2_mouse_stream_ctrl;
   import ps2_mouse_stream_ctrl_pkg::*;

   localparam int unsigned TO = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sel = 1'b0;
   logic       en_s = 1'b0, dis_s = 1'b0, clr_s = 1'b0, rx_v = 1'b0, tx_v = 1'b0;
   logic [7:0] rx_b = 8'h00;

   int checks = 0;
   int failures = 0;
   int f4_3 = 0, f5_3 = 0, pk_3 = 0, dd_3 = 0, er_3 = 0, pk_4 = 0;

   always #5 clk = ~clk;

   ps2_mouse_stream_ctrl_if bus3();
   ps2_mouse_stream_ctrl_if bus4();

   assign bus3.rx_data      = rx_b;
   assign bus3.rx_done_tick = rx_v & ~sel;
   assign bus3.tx_done_tick = tx_v & ~sel;
   assign bus4.rx_data      = rx_b;
   assign bus4.rx_done_tick = rx_v & sel;
   assign bus4.tx_done_tick = tx_v & sel;

   logic [8:0]         xd3, yd3, xd4, yd4;
   logic [3:0]         zd3, zd4;
   logic [2:0]         btn3, btn4;
   logic               xo3, yo3, xo4, yo4;
   logic signed [11:0] xp3, yp3;
   logic signed [7:0]  xp4, yp4;
   logic               str3, pkt3, dd3, er3, str4, pkt4t, dd4, er4;

   ps2_mouse_stream_ctrl #(.PKT_BYTES(3), .POS_W(12), .TO_CYCLES(TO), .MAX_RETRY(3)) dut3 (
      .clk(clk), .rst(rst),
      .stream_enable(en_s & ~sel), .stream_disable(dis_s & ~sel), .pos_clr(clr_s & ~sel),
      .ps2(bus3),
      .x_delta(xd3), .y_delta(yd3), .z_delta(zd3), .btn(btn3), .x_ovf(xo3), .y_ovf(yo3),
      .x_pos(xp3), .y_pos(yp3), .streaming(str3), .package_done_tick(pkt3),
      .disable_done_tick(dd3), .err_tick(er3)
   );

   ps2_mouse_stream_ctrl #(.PKT_BYTES(4), .POS_W(8), .TO_CYCLES(TO), .MAX_RETRY(3)) dut4 (
      .clk(clk), .rst(rst),
      .stream_enable(en_s & sel), .stream_disable(dis_s & sel), .pos_clr(clr_s & sel),
      .ps2(bus4),
      .x_delta(xd4), .y_delta(yd4), .z_delta(zd4), .btn(btn4), .x_ovf(xo4), .y_ovf(yo4),
      .x_pos(xp4), .y_pos(yp4), .streaming(str4), .package_done_tick(pkt4t),
      .disable_done_tick(dd4), .err_tick(er4)
   );

   always @(posedge clk) begin
      if (bus3.wr_ps2 && bus3.tx_data == CMD_STREAM_ON)  f4_3 <= f4_3 + 1;
      if (bus3.wr_ps2 && bus3.tx_data == CMD_STREAM_OFF) f5_3 <= f5_3 + 1;
      if (pkt3)  pk_3 <= pk_3 + 1;
      if (dd3)   dd_3 <= dd_3 + 1;
      if (er3)   er_3 <= er_3 + 1;
      if (pkt4t) pk_4 <= pk_4 + 1;
   end

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_en();
      en_s = 1'b1; cyc(1); en_s = 1'b0;
   endtask

   task automatic pulse_dis();
      dis_s = 1'b1; cyc(1); dis_s = 1'b0;
   endtask

   task automatic tx_ack();
      cyc(1); tx_v = 1'b1; cyc(1); tx_v = 1'b0;
   endtask

   task automatic rx(input logic [7:0] b);
      rx_b = b; rx_v = 1'b1; cyc(1); rx_v = 1'b0; cyc(1);
   endtask

   task automatic pkt4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
      rx(b0); rx(b1); rx(b2); rx(b3); cyc(1);
   endtask

   initial begin
      int s, s2, d;
      cyc(3);
      chk("rst_streaming", str3, 0);
      chk("rst_wr_ps2", bus3.wr_ps2, 0);
      chk("rst_tx_data", bus3.tx_data, 0);
      chk("rst_x_pos", xp3, 0);
      chk("rst_x_delta", xd3, 0);
      chk("rst_pkg_tick", pkt3, 0);
      rst = 1'b0;
      cyc(2);

      // Enable handshake
      pulse_en();
      chk("send_wr", bus3.wr_ps2, 1);
      chk("send_data_f4", bus3.tx_data, CMD_STREAM_ON);
      tx_ack();
      rx(RSP_ACK);
      chk("stream_on", str3, 1);
      chk("f4_sent_once", f4_3, 1);

      // Byte 1 has ys set so FE reads as -2
      s = pk_3;
      rx(8'h28); rx(8'h05); rx(8'hFE); cyc(1);
      chk("p1_ticks", pk_3 - s, 1);
      chk("p1_x_delta", xd3, 9'h005);
      chk("p1_y_delta", yd3, 9'h1FE);
      chk("p1_btn", btn3, 0);
      chk("p1_x_pos", xp3, 5);
      chk("p1_y_pos", yp3, -2);
      chk("p1_z_delta", zd3, 0);

      // Resync: 00 lacks bit 3 and is dropped
      s = pk_3;
      rx(8'h00); rx(8'h09); rx(8'h10); rx(8'h20); cyc(1);
      chk("resync_ticks", pk_3 - s, 1);
      chk("resync_x_delta", xd3, 9'h010);
      chk("resync_y_delta", yd3, 9'h020);
      chk("resync_btn", btn3, 1);
      chk("resync_x_pos", xp3, 21);
      chk("resync_y_pos", yp3, 30);

      // Disable after byte 2: packet completes, then F5
      s = pk_3; d = dd_3;
      rx(8'h08); rx(8'h03);
      pulse_dis();
      rx(8'h04);
      chk("dis_wr", bus3.wr_ps2, 1);
      chk("dis_data_f5", bus3.tx_data, CMD_STREAM_OFF);
      chk("dis_stream_off", str3, 0);
      tx_ack();
      rx(8'h09);
      chk("dis_stale_ignored", dd_3 - d, 0);
      rx(RSP_ACK);
      chk("dis_done_tick", dd_3 - d, 1);
      chk("dis_pkt_completed", pk_3 - s, 1);
      chk("dis_x_pos", xp3, 24);
      chk("dis_y_pos", yp3, 34);

      // No response: 4 attempts then error
      s = f4_3; d = er_3;
      pulse_en();
      cyc(120);
      chk("err_f4_count", f4_3 - s, 4);
      chk("err_tick_count", er_3 - d, 1);
      chk("err_streaming", str3, 0);

      // Resend request, then disable from PK1
      s = f4_3;
      pulse_en(); tx_ack(); rx(RSP_RESEND); tx_ack(); rx(RSP_ACK);
      chk("resend_f4_count", f4_3 - s, 2);
      chk("resend_streaming", str3, 1);
      s2 = f5_3; d = dd_3;
      pulse_dis();
      chk("pk1_dis_stream_off", str3, 0);
      tx_ack(); rx(RSP_ACK);
      chk("pk1_dis_f5_count", f5_3 - s2, 1);
      chk("pk1_dis_done", dd_3 - d, 1);

      // Wheel instance, 8-bit positions
      sel = 1'b1;
      pulse_en(); tx_ack(); rx(RSP_ACK);
      chk("w_stream_on", str4, 1);
      s = pk_4;
      pkt4(8'h08, 8'h7F, 8'h00, 8'h0F);
      chk("w_x_pos_127", xp4, 127);
      chk("w_x_delta", xd4, 9'h07F);
      chk("w_z_delta", zd4, 4'hF);
      chk("w_y_pos", yp4, 0);
      pkt4(8'h08, 8'h7F, 8'h00, 8'h0F);
      chk("w_x_pos_sat_hi", xp4, 127);
      pkt4(8'h18, 8'h7F, 8'h00, 8'h00);
      chk("w_x_pos_neg", xp4, -2);
      pkt4(8'h18, 8'h7F, 8'h00, 8'h00);
      chk("w_x_pos_sat_lo", xp4, -128);
      pkt4(8'h48, 8'h01, 8'h00, 8'h00);
      chk("w_ovf_x_pos", xp4, 127);
      chk("w_ovf_flag", xo4, 1);

      // pos_clr during the DONE cycle
      rx(8'h08); rx(8'h01); rx(8'h00);
      rx_b = 8'h0F; rx_v = 1'b1; cyc(1); rx_v = 1'b0;
      clr_s = 1'b1; cyc(1); clr_s = 1'b0; cyc(1);
      chk("w_clr_x_pos", xp4, 0);
      chk("w_clr_x_delta", xd4, 9'h001);
      chk("w_clr_ticks", pk_4 - s, 6);

      // Inter-byte timeout drops the partial packet
      rx(8'h08); rx(8'h05);
      cyc(25);
      pkt4(8'h08, 8'h02, 8'h00, 8'h01);
      chk("w_abort_ticks", pk_4 - s, 7);
      chk("w_abort_x_delta", xd4, 9'h002);
      chk("w_abort_x_pos", xp4, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sequence did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
